// File: rtl/par_to_ser_pkg.sv
// Shared constants and helpers for the multi-lane serializer.
// HDMI tops pick a TMDS control word here to use as the idle fill.
package par_to_ser_pkg;

    localparam logic [9:0] IDLE_DEFAULT = 10'h000;

    // TMDS control-period symbols for {c1,c0}
    localparam logic [9:0] TMDS_CTRL_00 = 10'b1101010100;
    localparam logic [9:0] TMDS_CTRL_01 = 10'b0010101011;
    localparam logic [9:0] TMDS_CTRL_10 = 10'b0101010100;
    localparam logic [9:0] TMDS_CTRL_11 = 10'b1010101011;

    function automatic int slots_of(input int data_w, input bit ddr);
        return ddr ? data_w / 2 : data_w;
    endfunction

endpackage

// File: rtl/ddio_out.sv
// Behavioural model of the vendor DDR output wrapper: both halves are
// captured on the rising outclock edge, high half shown while outclock is high.
module ddio_out #(
    parameter int WIDTH = 1
) (
    input  logic             outclock,
    input  logic [WIDTH-1:0] datain_h,
    input  logic [WIDTH-1:0] datain_l,
    output logic [WIDTH-1:0] dataout
);

    logic [WIDTH-1:0] h_q;
    logic [WIDTH-1:0] l_q;

    always_ff @(posedge outclock) begin
        h_q <= datain_h;
        l_q <= datain_l;
    end

    assign dataout = outclock ? h_q : l_q;

endmodule

// File: rtl/par_to_ser_multi_ser_lane.sv
// One serializer lane: bit-order select, shift register and the
// registered rise/fall bits feeding the DDR output cell.
module ser_lane #(
    parameter int DATA_W    = 10,
    parameter bit DDR       = 1'b1,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic              clk_ser,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] word,
    output logic              rise_bit,
    output logic              fall_bit
);

    localparam int STEP = DDR ? 2 : 1;

    logic [DATA_W-1:0] ordered;
    logic [DATA_W-1:0] sr;
    logic [DATA_W-1:0] src;

    always_comb begin
        ordered = word;
        for (int i = 0; i < DATA_W; i++) begin
            ordered[i] = MSB_FIRST ? word[DATA_W-1-i] : word[i];
        end
    end

    // The first slot goes straight to rise/fall so it leaves one cycle after load
    assign src = load ? ordered : sr;

    always_ff @(posedge clk_ser) begin
        if (rst) begin
            sr       <= '0;
            rise_bit <= 1'b0;
            fall_bit <= 1'b0;
        end else begin
            sr       <= src >> STEP;
            rise_bit <= src[0];
            fall_bit <= DDR ? src[1] : src[0];
        end
    end

endmodule

// File: rtl/par_to_ser_multi.sv
// Multi-lane DDR/SDR serializer with shared phase counter, idle fill on
// underrun and one-slot bitslip for word-boundary alignment.
module par_to_ser_multi
    import par_to_ser_pkg::*;
#(
    parameter int              DATA_W    = 10,
    parameter int              LANES     = 4,
    parameter bit              DDR       = 1'b1,
    parameter bit              MSB_FIRST = 1'b0,
    parameter logic [DATA_W-1:0] IDLE_WORD = DATA_W'(IDLE_DEFAULT)
) (
    input  logic                    clk_ser,
    input  logic                    rst,
    input  logic [LANES*DATA_W-1:0] data_in,
    input  logic                    data_valid,
    output logic                    data_ready,
    input  logic                    bitslip,
    output logic                    underrun,
    output logic [LANES-1:0]        ser_p,
    output logic [LANES-1:0]        ser_n
);

    localparam int SLOTS = slots_of(DATA_W, DDR);
    localparam int PW    = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam logic [PW-1:0] LAST = PW'(SLOTS - 1);

    logic [PW-1:0]    phase;
    logic             pending;
    logic             hold;
    logic             at_last;
    logic             stretch;
    logic             load;
    logic [LANES-1:0] rise;
    logic [LANES-1:0] fall;
    logic             out_clk;

    assign at_last    = (phase == LAST);
    // A pending slip spends one extra cycle at the load phase before loading
    assign stretch    = at_last && pending && !hold;
    assign load       = at_last && !stretch;
    assign data_ready = load && !rst;

    always_ff @(posedge clk_ser) begin
        if (rst) begin
            phase    <= '0;
            pending  <= 1'b0;
            hold     <= 1'b0;
            underrun <= 1'b0;
        end else begin
            underrun <= load && !data_valid;
            if (load) begin
                phase   <= '0;
                hold    <= 1'b0;
                pending <= bitslip;
            end else if (stretch) begin
                hold <= 1'b1;
            end else begin
                phase   <= phase + PW'(1);
                pending <= pending | bitslip;
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [DATA_W-1:0] word;

        assign word = data_valid ? data_in[i*DATA_W +: DATA_W]
                                 : IDLE_WORD;

        ser_lane #(
            .DATA_W   (DATA_W),
            .DDR      (DDR),
            .MSB_FIRST(MSB_FIRST)
        ) u_lane (
            .clk_ser (clk_ser),
            .rst     (rst),
            .load    (load),
            .word    (word),
            .rise_bit(rise[i]),
            .fall_bit(fall[i])
        );
    end

    assign out_clk = ~clk_ser;

    ddio_out #(.WIDTH(LANES)) u_ddio_p (
        .outclock(out_clk),
        .datain_h(rise),
        .datain_l(fall),
        .dataout (ser_p)
    );

    ddio_out #(.WIDTH(LANES)) u_ddio_n (
        .outclock(out_clk),
        .datain_h(~rise),
        .datain_l(~fall),
        .dataout (ser_n)
    );

endmodule

// File: tb/tb_par_to_ser_multi.sv
// Scoreboard bench for par_to_ser_multi over three configurations:
// 4-lane DDR LSB-first, 1-lane DDR MSB-first, 2-lane SDR 8-bit.
module tb_par_to_ser_multi;
    import par_to_ser_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input int cfg, input string nm,
                       input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL cfg%0d %s: got %0h, want %0h", cfg, nm, got, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int DW = (g == 2) ? 8 : 10;
        localparam bit DD = (g != 2);
        localparam bit MF = (g == 1);
        localparam int LN = (g == 0) ? 4 : ((g == 1) ? 1 : 2);
        localparam int SL = DD ? DW / 2 : DW;
        localparam logic [DW-1:0] IW =
            (g == 2) ? DW'(8'h3C) : DW'(TMDS_CTRL_00);
        localparam logic [DW-1:0] FIX =
            (g == 2) ? DW'(8'hA5) : DW'(10'b1100101010);

        logic                 rst;
        logic [LN*DW-1:0]     data_in;
        logic                 data_valid;
        logic                 data_ready;
        logic                 bitslip;
        logic                 underrun;
        logic [LN-1:0]        ser_p;
        logic [LN-1:0]        ser_n;
        logic [2*LN-1:0]      q[$];
        bit                   mon_en = 1'b0;
        bit                   fin = 1'b0;

        par_to_ser_multi #(
            .DATA_W   (DW),
            .LANES    (LN),
            .DDR      (DD),
            .MSB_FIRST(MF),
            .IDLE_WORD(IW)
        ) dut (
            .clk_ser   (clk),
            .rst       (rst),
            .data_in   (data_in),
            .data_valid(data_valid),
            .data_ready(data_ready),
            .bitslip   (bitslip),
            .underrun  (underrun),
            .ser_p     (ser_p),
            .ser_n     (ser_n)
        );

        // Bits of slot k for every lane, straight from the bit-mapping rules
        function automatic logic [2*LN-1:0] slot_bits(
            input logic [LN*DW-1:0] ws, input int k);
            logic [LN-1:0] r;
            logic [LN-1:0] f;
            logic [DW-1:0] w;
            int ri;
            int fi;
            r = '0;
            f = '0;
            for (int l = 0; l < LN; l++) begin
                w = ws[l*DW +: DW];
                if (DD) begin
                    ri = MF ? DW - 1 - 2 * k : 2 * k;
                    fi = MF ? DW - 2 - 2 * k : 2 * k + 1;
                end else begin
                    ri = MF ? DW - 1 - k : k;
                    fi = ri;
                end
                r[l] = w[ri];
                f[l] = w[fi];
            end
            return {r, f};
        endfunction

        // Driver and schedule model: loads every SL cycles, one extra
        // zero slot before the load that consumes a pending slip.
        initial begin
            int c;
            int nominal;
            bit pend;
            bit strt;
            bit st;
            bit ld;
            bit ur;
            bit did_rst;
            logic [LN*DW-1:0] w;

            rst        = 1'b1;
            data_valid = 1'b0;
            bitslip    = 1'b0;
            data_in    = '0;
            did_rst    = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            chk(g, "rst_ready", 64'(data_ready), 64'(0));
            chk(g, "rst_ser_p", 64'(ser_p), 64'(0));
            chk(g, "rst_ser_n", 64'(ser_n), 64'({LN{1'b1}}));
            chk(g, "rst_underrun", 64'(underrun), 64'(0));
            rst     = 1'b0;
            c       = 0;
            nominal = SL - 1;
            pend    = 1'b0;
            strt    = 1'b0;
            ur      = 1'b0;
            for (int k = 0; k < SL; k++) q.push_back('0);
            mon_en = 1'b1;

            for (int total = 0; total < 500; total++) begin
                if (!did_rst && c >= 200 && !strt
                    && nominal - c == SL - 3) begin
                    did_rst = 1'b1;
                    mon_en  = 1'b0;
                    rst     = 1'b1;
                    bitslip = 1'b0;
                    repeat (3) begin
                        chk(g, "mid_rst_ready", 64'(data_ready), 64'(0));
                        @(posedge clk);
                        #1;
                    end
                    chk(g, "mid_rst_ser_p", 64'(ser_p), 64'(0));
                    chk(g, "mid_rst_ser_n", 64'(ser_n), 64'({LN{1'b1}}));
                    chk(g, "mid_rst_underrun", 64'(underrun), 64'(0));
                    q.delete();
                    rst     = 1'b0;
                    c       = 0;
                    nominal = SL - 1;
                    pend    = 1'b0;
                    strt    = 1'b0;
                    ur      = 1'b0;
                    for (int k = 0; k < SL; k++) q.push_back('0);
                    mon_en = 1'b1;
                end

                if (!did_rst && c < 4 * SL) begin
                    data_valid = (c != 2 * SL - 1);
                    data_in    = {LN{FIX}};
                    bitslip    = 1'b0;
                end else begin
                    data_valid = ($urandom_range(0, 4) != 0);
                    for (int l = 0; l < LN; l++)
                        data_in[l*DW +: DW] = DW'($urandom);
                    bitslip = (c == 4 * SL + 1) || (c == 4 * SL + 2)
                           || (c >= 6 * SL && $urandom_range(0, 15) == 0);
                end

                st = (c == nominal) && pend && !strt;
                ld = (c == nominal) && !st;
                chk(g, "ready", 64'(data_ready), 64'(ld));
                chk(g, "underrun", 64'(underrun), 64'(ur));
                ur = ld && !data_valid;

                if (st) begin
                    q.push_back('0);
                    strt    = 1'b1;
                    nominal = c + 1;
                end else if (ld) begin
                    w = data_valid ? data_in : {LN{IW}};
                    for (int k = 0; k < SL; k++) q.push_back(slot_bits(w, k));
                    strt    = 1'b0;
                    pend    = bitslip;
                    nominal = c + SL;
                end else if (bitslip) begin
                    pend = 1'b1;
                end

                @(posedge clk);
                #1;
                c++;
            end
            bitslip = 1'b0;
            mon_en  = 1'b0;
            repeat (2) @(posedge clk);
            fin = 1'b1;
        end

        // Monitor: rise half shows while clk is low, fall half after posedge
        initial begin
            logic [LN-1:0]   r;
            logic [LN-1:0]   f;
            logic [LN-1:0]   rn;
            logic [LN-1:0]   fn;
            logic [2*LN-1:0] e;
            forever begin
                @(negedge clk);
                if (mon_en) begin
                    #2;
                    r  = ser_p;
                    rn = ser_n;
                    @(posedge clk);
                    #2;
                    f  = ser_p;
                    fn = ser_n;
                    if (q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL cfg%0d slot: got %b/%b, want none",
                                 g, r, f);
                    end else begin
                        e = q.pop_front();
                        chk(g, "slot", 64'({r, f, rn, fn}), 64'({e, ~e}));
                    end
                end
            end
        end
    end

    initial begin
        fork
            wait (g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin);
            #200000;
        join_any
        if (!(g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin)) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: got unfinished, want all done");
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
